// File: rtl/vdc_iter_32bit_pkg.sv
// Shared definitions for the low-discrepancy sequence blocks
// (vdc_iter_32bit and disk_32bit): word width, generator states and
// compile-time power helpers used to size the fixed-point full scale.
package lds_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } vdc_state_t;

    // base**exp truncated to 32 bits; only meaningful once the range has been
    // checked with ipow_sat.
    function automatic int unsigned ipow(input int unsigned base, input int unsigned exp);
        int unsigned result;
        result = 1;
        for (int unsigned i = 0; i < exp; i++) begin
            result = result * base;
        end
        return result;
    endfunction

    // base**exp saturated at 2**32 so an out-of-range parameter set can be
    // detected without the product silently wrapping.
    function automatic logic [63:0] ipow_sat(input int unsigned base, input int unsigned exp);
        logic [63:0] result;
        result = 64'd1;
        for (int unsigned i = 0; i < exp; i++) begin
            result = result * 64'(base);
            if (result > 64'h1_0000_0000) begin
                result = 64'h1_0000_0000;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/vdc_iter_32bit_if.sv
// Request/result bundle of one van der Corput generator. The consumer
// (e.g. disk_32bit or a testbench) takes the master side; the generator
// takes the slave side.
interface vdc_iter_32bit_if;

    logic                      pop_enable;
    logic [lds_pkg::WORD_W-1:0] seed;
    logic                      reseed_enable;
    logic [lds_pkg::WORD_W-1:0] vdc_out;
    logic                      valid;
    logic                      busy;

    modport master (
        output pop_enable,
        output seed,
        output reseed_enable,
        input  vdc_out,
        input  valid,
        input  busy
    );

    modport slave (
        input  pop_enable,
        input  seed,
        input  reseed_enable,
        output vdc_out,
        output valid,
        output busy
    );

endinterface

// File: rtl/vdc_iter_32bit_divmod.sv
// Combinational quotient/remainder of a 32-bit word by a constant divisor.
// With DIV fixed at elaboration, synthesis reduces this to shifts/masks for
// powers of two and to a constant-divider network otherwise.
module divmod_const #(
    parameter int unsigned DIV = 2
) (
    input  logic [31:0] dividend,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam logic [31:0] DIV_W = 32'(DIV);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("divmod_const: DIV must be at least 2");
        end
    endgenerate

    assign quotient  = dividend / DIV_W;
    assign remainder = dividend % DIV_W;

endmodule

// File: rtl/vdc_iter_32bit.sv
// Iterative van der Corput generator. Each pop advances the index k and
// mirrors its base-BASE digits about the radix point, one digit per clock,
// producing a fixed-point value in [0, BASE**SCALE).
module vdc_iter_32bit
    import lds_pkg::*;
#(
    parameter int unsigned BASE  = 2,
    parameter int unsigned SCALE = 16
) (
    input logic             clk,
    input logic             rst,
    vdc_iter_32bit_if.slave bus
);

    localparam logic [WORD_W-1:0] FULL_SCALE = WORD_W'(ipow(BASE, SCALE));

    generate
        if (BASE < 2 || ipow_sat(BASE, SCALE) >= 64'h1_0000_0000) begin : g_bad_params
            $error("vdc_iter_32bit: need BASE >= 2 and BASE**SCALE < 2**32");
        end
    endgenerate

    vdc_state_t        state, state_next;
    logic [WORD_W-1:0] k, k_next;
    logic [WORD_W-1:0] q, q_next;
    logic [WORD_W-1:0] fac, fac_next;
    logic [WORD_W-1:0] acc, acc_next;
    logic [WORD_W-1:0] vdc_reg, vdc_next;
    logic              valid_reg, valid_next;

    logic [WORD_W-1:0] q_quot, q_rem;
    logic [WORD_W-1:0] fac_quot, fac_rem_unused;

    // Peel off the lowest remaining digit of the index.
    divmod_const #(.DIV(BASE)) u_div_q (
        .dividend  (q),
        .quotient  (q_quot),
        .remainder (q_rem)
    );

    // Weight for that digit: one place further right of the radix point.
    divmod_const #(.DIV(BASE)) u_div_fac (
        .dividend  (fac),
        .quotient  (fac_quot),
        .remainder (fac_rem_unused)
    );

    // Next-state and datapath update; reseed overrides everything else and
    // pop_enable is only honoured while idle.
    always_comb begin
        state_next = state;
        k_next     = k;
        q_next     = q;
        fac_next   = fac;
        acc_next   = acc;
        vdc_next   = vdc_reg;
        valid_next = 1'b0;

        if (bus.reseed_enable) begin
            k_next     = bus.seed;
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.pop_enable) begin
                        k_next     = k + 32'd1;
                        q_next     = k + 32'd1;
                        acc_next   = '0;
                        fac_next   = FULL_SCALE;
                        state_next = CALC;
                    end
                end
                CALC: begin
                    q_next   = q_quot;
                    fac_next = fac_quot;
                    acc_next = acc + q_rem * fac_quot;
                    if (q_quot == '0) begin
                        vdc_next   = acc + q_rem * fac_quot;
                        valid_next = 1'b1;
                        state_next = DONE;
                    end
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State register; reset drops any calculation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Index, work registers and the held result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k         <= '0;
            q         <= '0;
            fac       <= '0;
            acc       <= '0;
            vdc_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            k         <= k_next;
            q         <= q_next;
            fac       <= fac_next;
            acc       <= acc_next;
            vdc_reg   <= vdc_next;
            valid_reg <= valid_next;
        end
    end

    assign bus.vdc_out = vdc_reg;
    assign bus.valid   = valid_reg;
    assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_vdc_iter_32bit.sv
// Self-checking bench for vdc_iter_32bit: a BASE=2/SCALE=16 instance takes
// directed and random pops/reseeds, a BASE=3/SCALE=10 instance runs a held
// pop sequence. Expected values come from a digit-reversal reference model.
module tb_vdc_iter_32bit;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    vdc_iter_32bit_if bus2 ();
    vdc_iter_32bit_if bus3 ();

    vdc_iter_32bit #(.BASE(2), .SCALE(16)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    vdc_iter_32bit #(.BASE(3), .SCALE(10)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] model_k2    = 32'd0;
    logic [31:0] last_out2   = 32'd0;

    // Radical inverse: write the first SCALE base-b digits of k in reverse
    // order as an integer, i.e. vdc(k) scaled by base**scale.
    function automatic longint unsigned refVdc(input longint unsigned k, input int base, input int scale);
        longint unsigned rev = 0;
        longint unsigned kk  = k;
        for (int i = 0; i < scale; i++) begin
            rev = rev * longint'(base) + kk % longint'(base);
            kk  = kk / longint'(base);
        end
        return rev;
    endfunction

    // Number of base-b digits in k (zero counts as one digit).
    function automatic int digitCount(input longint unsigned k, input int base);
        int d = 1;
        longint unsigned kk = k / longint'(base);
        while (kk != 0) begin
            d++;
            kk = kk / longint'(base);
        end
        return d;
    endfunction

    task automatic checkOutput(input string tag, input longint unsigned observed, input longint unsigned expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic reseedTo(input logic [31:0] s);
        @(negedge clk);
        bus2.seed          = s;
        bus2.reseed_enable = 1'b1;
        @(negedge clk);
        bus2.reseed_enable = 1'b0;
        bus2.seed          = $urandom;
        model_k2           = s;
    endtask

    // One pop on the base-2 instance with value, latency and pulse checks.
    task automatic applyStimulus();
        int lat  = 0;
        bit seen = 1'b0;
        longint unsigned expected_value;
        @(negedge clk);
        bus2.pop_enable = 1'b1;
        @(posedge clk);
        #1 bus2.pop_enable = 1'b0;
        model_k2 = model_k2 + 32'd1;
        expected_value = refVdc(model_k2, 2, 16);
        while (!seen && lat < 40) begin
            @(posedge clk);
            lat++;
            #1;
            if (bus2.valid) seen = 1'b1;
        end
        checkOutput("pop_done", seen, 1);
        if (seen) begin
            checkOutput("latency", lat, digitCount(model_k2, 2));
            checkOutput("vdc_value", bus2.vdc_out, expected_value);
            last_out2 = 32'(expected_value);
            @(posedge clk);
            #1;
            checkOutput("valid_width", bus2.valid, 0);
            checkOutput("busy_after_done", bus2.busy, 0);
        end
    endtask

    initial begin
        int n2, n3, cyc, t2, t3, valid_seen;
        logic [31:0] s;

        rst                = 1'b1;
        bus2.pop_enable    = 1'b0;
        bus2.reseed_enable = 1'b0;
        bus2.seed          = 32'd0;
        bus3.pop_enable    = 1'b0;
        bus3.reseed_enable = 1'b0;
        bus3.seed          = 32'd0;

        repeat (2) @(negedge clk);
        checkOutput("reset_vdc2", bus2.vdc_out, 0);
        checkOutput("reset_valid2", bus2.valid, 0);
        checkOutput("reset_busy2", bus2.busy, 0);
        checkOutput("reset_vdc3", bus3.vdc_out, 0);
        checkOutput("reset_valid3", bus3.valid, 0);
        checkOutput("reset_busy3", bus3.busy, 0);

        // Held pop on both bases: five values each, back to back.
        rst = 1'b0;
        bus2.pop_enable = 1'b1;
        bus3.pop_enable = 1'b1;
        n2 = 0; n3 = 0; cyc = 0; t2 = 0; t3 = 0;
        while ((n2 < 5 || n3 < 5) && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (bus2.valid && n2 < 5) begin
                n2++;
                checkOutput("held_vdc2", bus2.vdc_out, refVdc(n2, 2, 16));
                if (n2 > 1) checkOutput("held_gap2", cyc - t2, digitCount(n2, 2) + 2);
                t2 = cyc;
                if (n2 == 5) bus2.pop_enable = 1'b0;
            end
            if (bus3.valid && n3 < 5) begin
                n3++;
                checkOutput("held_vdc3", bus3.vdc_out, refVdc(n3, 3, 10));
                if (n3 > 1) checkOutput("held_gap3", cyc - t3, digitCount(n3, 3) + 2);
                t3 = cyc;
                if (n3 == 5) bus3.pop_enable = 1'b0;
            end
        end
        checkOutput("held_count2", n2, 5);
        checkOutput("held_count3", n3, 5);
        model_k2 = 32'd5;
        repeat (4) @(negedge clk);
        checkOutput("hold_vdc2", bus2.vdc_out, refVdc(5, 2, 16));
        checkOutput("hold_vdc3", bus3.vdc_out, refVdc(5, 3, 10));
        checkOutput("idle_busy2", bus2.busy, 0);
        last_out2 = 32'(refVdc(5, 2, 16));

        // Latency corner cases and the reseed-then-pop sequence.
        reseedTo(32'd0);
        applyStimulus();
        reseedTo(32'd3);
        applyStimulus();
        reseedTo(32'd5);
        applyStimulus();
        applyStimulus();

        // Asynchronous reset in the middle of a long calculation.
        reseedTo(32'h00F0_0000);
        @(negedge clk);
        bus2.pop_enable = 1'b1;
        @(posedge clk);
        #1 bus2.pop_enable = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("busy_before_rst", bus2.busy, 1);
        rst = 1'b1;
        #1;
        checkOutput("rst_vdc", bus2.vdc_out, 0);
        checkOutput("rst_valid", bus2.valid, 0);
        checkOutput("rst_busy", bus2.busy, 0);
        @(negedge clk);
        rst = 1'b0;
        model_k2  = 32'd0;
        last_out2 = 32'd0;
        applyStimulus();

        // Index wrap from all-ones back to zero.
        reseedTo(32'hFFFF_FFFF);
        applyStimulus();
        applyStimulus();

        // Reseed while calculating discards the in-flight value.
        reseedTo(32'h8000_0000 | $urandom);
        @(negedge clk);
        bus2.pop_enable = 1'b1;
        @(posedge clk);
        #1 bus2.pop_enable = 1'b0;
        repeat (2) @(posedge clk);
        s = $urandom;
        reseedTo(s);
        valid_seen = 0;
        checkOutput("abort_busy", bus2.busy, 0);
        repeat (40) begin
            @(negedge clk);
            if (bus2.valid) valid_seen++;
        end
        checkOutput("abort_no_valid", valid_seen, 0);
        checkOutput("abort_hold", bus2.vdc_out, last_out2);
        applyStimulus();

        // Reseed and pop together while idle: reseed only.
        s = $urandom;
        @(negedge clk);
        bus2.seed          = s;
        bus2.reseed_enable = 1'b1;
        bus2.pop_enable    = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("combo_valid", bus2.valid, 0);
        checkOutput("combo_busy", bus2.busy, 0);
        @(negedge clk);
        bus2.reseed_enable = 1'b0;
        bus2.pop_enable    = 1'b0;
        model_k2 = s;
        applyStimulus();

        // Random mix of reseeds and pops.
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 1) == 1) reseedTo($urandom);
            applyStimulus();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
